// File: rtl/sdp_bram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdp_bram_pkg
// Description : Shared types and helpers for the byte-enable SDP block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package sdp_bram_pkg;

    localparam int MAX_DBITS  = 256;
    localparam int MAX_NBYTES = 32;

    typedef enum logic {
        RDW_READ_FIRST  = 1'b0,
        RDW_WRITE_FIRST = 1'b1
    } rdw_mode_e;

    typedef enum logic [0:0] {
        CLR_ST_CLEAR = 1'b0,
        CLR_ST_READY = 1'b1
    } clr_state_e;

    function automatic int lane_count(input int dbits, input int bytewidth);
        return dbits / bytewidth;
    endfunction

    // Works on maximum-width vectors; callers size-cast in and out.
    function automatic logic [MAX_DBITS-1:0] byte_merge(
        input logic [MAX_DBITS-1:0]  old_word,
        input logic [MAX_DBITS-1:0]  new_word,
        input logic [MAX_NBYTES-1:0] be,
        input int                    bytewidth
    );
        logic [MAX_DBITS-1:0] res;
        int                   lane;
        res = old_word;
        for (int i = 0; i < MAX_DBITS; i++) begin
            lane = i / bytewidth;
            if (lane < MAX_NBYTES && be[lane]) begin
                res[i] = new_word[i];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_bram_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : sdp_bram_clear_seq
// Description : Post-reset sequencer that zeroes every word once, then idles.
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_bram_clear_seq
    import sdp_bram_pkg::*;
#(
    parameter int ABITS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             clr_we_o,
    output logic [ABITS-1:0] clr_addr_o,
    output logic             busy_o
);

    clr_state_e       state_q, state_d;
    logic [ABITS-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_o = 1'b0;
        busy_o   = 1'b0;
        case (state_q)
            CLR_ST_CLEAR: begin
                busy_o   = 1'b1;
                clr_we_o = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = CLR_ST_READY;
                end
            end
            default: begin
                state_d = CLR_ST_READY;
            end
        endcase
    end

    assign clr_addr_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/sdp_be_bram_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sdp_be_bram_pipe
// Description : Simple-dual-port byte-enable block RAM, read latency 1 or 2,
//               selectable same-address read-during-write behaviour.
//               Optional post-reset clear: define SDP_BE_INIT_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_be_bram_pipe
    import sdp_bram_pkg::*;
#(
    parameter  int ABITS      = 10,
    parameter  int DBITS      = 32,
    parameter  int BYTEWIDTH  = 8,
    parameter  int RD_LATENCY = 1,
    parameter  int RDW_MODE   = 0,
    localparam int NBYTES     = lane_count(DBITS, BYTEWIDTH),
    localparam int DEPTH      = 2 ** ABITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [NBYTES-1:0] be_i,
    input  logic [ABITS-1:0]  wa_i,
    input  logic [DBITS-1:0]  wd_i,
    input  logic              re_i,
    input  logic [ABITS-1:0]  ra_i,
    output logic [DBITS-1:0]  rd_o,
    output logic              rd_valid_o,
    output logic              busy_o
);

    if (DBITS % BYTEWIDTH != 0) begin : g_err_lanes
        $error("DBITS must be a multiple of BYTEWIDTH");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_err_latency
        $error("RD_LATENCY must be 1 or 2");
    end
    if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_err_rdw
        $error("RDW_MODE must be 0 or 1");
    end
    if (DBITS > MAX_DBITS) begin : g_err_width
        $error("DBITS exceeds MAX_DBITS of sdp_bram_pkg");
    end

    (* syn_ramstyle = "block_ram" *) logic [DBITS-1:0] mem [DEPTH];

    logic              w_busy;
    logic              w_mem_we;
    logic [NBYTES-1:0] w_mem_be;
    logic [ABITS-1:0]  w_mem_wa;
    logic [DBITS-1:0]  w_mem_wd;

`ifdef SDP_BE_INIT_CLEAR_EN
    logic             w_clr_we;
    logic [ABITS-1:0] w_clr_addr;

    sdp_bram_clear_seq #(
        .ABITS (ABITS)
    ) u_clear_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_we_o   (w_clr_we),
        .clr_addr_o (w_clr_addr),
        .busy_o     (w_busy)
    );

    // The sequencer owns the write port while busy; user traffic is dropped.
    always_comb begin
        w_mem_we = we_i;
        w_mem_be = be_i;
        w_mem_wa = wa_i;
        w_mem_wd = wd_i;
        if (w_busy) begin
            w_mem_we = w_clr_we;
            w_mem_be = '1;
            w_mem_wa = w_clr_addr;
            w_mem_wd = '0;
        end
    end
`else
    assign w_busy   = 1'b0;
    assign w_mem_we = we_i;
    assign w_mem_be = be_i;
    assign w_mem_wa = wa_i;
    assign w_mem_wd = wd_i;
`endif

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (w_mem_we && w_mem_be[i]) begin
                mem[w_mem_wa][i*BYTEWIDTH +: BYTEWIDTH] <= w_mem_wd[i*BYTEWIDTH +: BYTEWIDTH];
            end
        end
    end

    logic             w_re;
    logic [DBITS-1:0] w_old;
    logic [DBITS-1:0] rd_s1_d;
    logic [DBITS-1:0] rd_s1_q;
    logic             vld_s1_q;

    assign w_re  = re_i & ~w_busy;
    assign w_old = mem[ra_i];

    if (RDW_MODE == int'(RDW_WRITE_FIRST)) begin : g_rdw_write_first
        logic w_coll;
        assign w_coll = w_mem_we & (ra_i == w_mem_wa);
        always_comb begin
            rd_s1_d = w_old;
            if (w_coll) begin
                rd_s1_d = DBITS'(byte_merge(MAX_DBITS'(w_old), MAX_DBITS'(w_mem_wd),
                                            MAX_NBYTES'(w_mem_be), BYTEWIDTH));
            end
        end
    end else begin : g_rdw_read_first
        assign rd_s1_d = w_old;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_s1_q  <= '0;
            vld_s1_q <= 1'b0;
        end else begin
            vld_s1_q <= w_re;
            if (w_re) begin
                rd_s1_q <= rd_s1_d;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DBITS-1:0] rd_s2_q;
        logic             vld_s2_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_s2_q  <= '0;
                vld_s2_q <= 1'b0;
            end else begin
                vld_s2_q <= vld_s1_q;
                if (vld_s1_q) begin
                    rd_s2_q <= rd_s1_q;
                end
            end
        end

        assign rd_o       = rd_s2_q;
        assign rd_valid_o = vld_s2_q;
    end else begin : g_lat1
        assign rd_o       = rd_s1_q;
        assign rd_valid_o = vld_s1_q;
    end

    assign busy_o = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_sdp_be_bram_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdp_be_bram_pipe
// Description : Scoreboard bench: latency-1/read-first and latency-2/
//               write-first instances driven by the same directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdp_be_bram_pipe;

`ifdef SDP_BE_INIT_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we_i, re_i;
    logic [3:0]  be_i, wa_i, ra_i;
    logic [31:0] wd_i;
    logic [31:0] rd0, rd1;
    logic        vld0, vld1, busy0, busy1;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] last0 = '0;
    logic [31:0] last1 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdp_be_bram_pipe #(.ABITS(4), .DBITS(32), .BYTEWIDTH(8), .RD_LATENCY(1), .RDW_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .we_i(we_i), .be_i(be_i), .wa_i(wa_i), .wd_i(wd_i),
        .re_i(re_i), .ra_i(ra_i), .rd_o(rd0), .rd_valid_o(vld0), .busy_o(busy0));

    sdp_be_bram_pipe #(.ABITS(4), .DBITS(32), .BYTEWIDTH(8), .RD_LATENCY(2), .RDW_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .we_i(we_i), .be_i(be_i), .wa_i(wa_i), .wd_i(wd_i),
        .re_i(re_i), .ra_i(ra_i), .rd_o(rd1), .rd_valid_o(vld1), .busy_o(busy1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor(input int k, input logic [31:0] rd, input logic v);
        exp_t e;
        if (v) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL dut%0d unexpected_valid: got rd=%h with no pending read", k, rd);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("dut%0d rd_data", k), rd, e.data);
                check($sformatf("dut%0d rd_cycle", k), cyc, e.due);
                if (k == 0) last0 = e.data; else last1 = e.data;
            end
        end else begin
            check($sformatf("dut%0d rd_hold", k), rd, (k == 0) ? last0 : last1);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            monitor(0, rd0, vld0);
            monitor(1, rd1, vld1);
        end
    end

    task automatic op(input logic we, input logic [3:0] be, input logic [3:0] wa,
                      input logic [31:0] wd, input logic re, input logic [3:0] ra,
                      input logic [31:0] e0, input logic [31:0] e1);
        we_i = we; be_i = be; wa_i = wa; wd_i = wd; re_i = re; ra_i = ra;
        if (re) begin
            q0.push_back('{e0, cyc + 1});
            q1.push_back('{e1, cyc + 2});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic rd_both(input logic [3:0] ra, input logic [31:0] e);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, ra, e, e);
    endtask

    task automatic do_reset();
        int n;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
        #1;
        check("reset rd0", rd0, 32'h0);
        check("reset rd1", rd1, 32'h0);
        check("reset vld0", {31'h0, vld0}, 32'h0);
        check("reset vld1", {31'h0, vld1}, 32'h0);
        check("reset busy0", {31'h0, busy0}, {31'h0, CLR});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        // Clear window: attempt a write and a read that must both be ignored.
        while (busy0 && n < 100) begin
            if (n == 2) op(1'b1, 4'hF, 4'h7, 32'hDEADBEEF, 1'b1, 4'h7, 32'h0, 32'h0);
            else        idle(1);
            if (n == 2) begin
                void'(q0.pop_back());
                void'(q1.pop_back());
            end
            n++;
        end
        check("busy_cycles", n, CLR ? 32'd16 : 32'd0);
        check("busy1_after", {31'h0, busy1}, 32'h0);
    endtask

    initial begin
        we_i = 1'b0; re_i = 1'b0; be_i = '0; wa_i = '0; wd_i = '0; ra_i = '0;
        @(posedge clk); #1;
        do_reset();

        op(1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 1'b0, 4'd0, 32'h0, 32'h0);
        rd_both(4'd5, 32'hAABBCCDD);
        op(1'b1, 4'b0011, 4'd5, 32'h00005566, 1'b1, 4'd5, 32'hAABBCCDD, 32'hAABB5566);
        rd_both(4'd5, 32'hAABB5566);
        op(1'b1, 4'hF, 4'd6, 32'hAABBCCDD, 1'b0, 4'd0, 32'h0, 32'h0);
        op(1'b1, 4'b0101, 4'd6, 32'h11223344, 1'b0, 4'd0, 32'h0, 32'h0);
        rd_both(4'd6, 32'hAA22CC44);
        op(1'b1, 4'hF, 4'd1, 32'h11111111, 1'b1, 4'd5, 32'hAABB5566, 32'hAABB5566);
        op(1'b1, 4'hF, 4'd2, 32'h22222222, 1'b0, 4'd0, 32'h0, 32'h0);
        op(1'b1, 4'hF, 4'd3, 32'h33333333, 1'b0, 4'd0, 32'h0, 32'h0);
        op(1'b1, 4'h0, 4'd1, 32'hFFFFFFFF, 1'b0, 4'd0, 32'h0, 32'h0);
        idle(2);
        rd_both(4'd1, 32'h11111111);
        rd_both(4'd2, 32'h22222222);
        rd_both(4'd3, 32'h33333333);
        idle(3);

        rd_both(4'd1, 32'h11111111);
        rd_both(4'd2, 32'h22222222);
        rd_both(4'd3, 32'h33333333);
        re_i = 1'b0;
        check("midburst vld1", {31'h0, vld1}, 32'h1);
        do_reset();
        check("post-reset rd1", rd1, 32'h0);

        rd_both(4'd1, CLR ? 32'h0 : 32'h11111111);
        rd_both(4'd2, CLR ? 32'h0 : 32'h22222222);
        rd_both(4'd3, CLR ? 32'h0 : 32'h33333333);
        rd_both(4'd6, CLR ? 32'h0 : 32'hAA22CC44);
        if (CLR) rd_both(4'd7, 32'h0);
        idle(4);

        check("q0 drained", q0.size(), 32'd0);
        check("q1 drained", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
